count_ones_feeder: RTL
======================

COUNT_ONES_FEEDER -- requirements
Module: count_ones_feeder

Interface
REQ-001 Parameter word_size, default 4: width of words sent to the counter.
REQ-002 Parameter counter_size, default 3: width of the counter's bit_count.
REQ-003 Parameter fifo_depth, default 4: input FIFO entries, power of two, minimum 2.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 reset  input  1: asynchronous, active-high reset.
REQ-006 in_data  input  word_size: word to be counted.
REQ-007 in_valid  input  1: in_data is offered this cycle.
REQ-008 in_ready  output  1: feeder accepts in_data this cycle.
REQ-009 data  output  word_size: word presented to the ones counter.
REQ-010 start  output  1: one-cycle launch request to the ones counter.
REQ-011 busy  input  1: counter is in its counting state.
REQ-012 done  input  1: counter is in its waiting state; bit_count is final.
REQ-013 bit_count  input  counter_size: counter result.
REQ-014 result_count  output  counter_size: captured result of the last completed word.
REQ-015 result_valid  output  1: one-cycle pulse; result_count is new.

Function
REQ-016 A word is accepted on a rising edge with in_valid=1 and in_ready=1; in_ready = FIFO not full, independent of any same-cycle pop.
REQ-017 Words are issued to the counter strictly in acceptance order; none is dropped or duplicated.
REQ-018 FSM states: S_IDLE, S_ISSUE, S_RUN.
REQ-019 S_IDLE: FIFO non-empty -> S_ISSUE; otherwise stay in S_IDLE.
REQ-020 S_ISSUE: start=1 for exactly this cycle and data = FIFO head; the head is popped on the exiting edge; -> S_RUN.
REQ-021 S_RUN: done=1 -> result_count <= bit_count, result_valid pulses for one cycle, -> S_IDLE; otherwise stay in S_RUN.
REQ-022 done is ignored outside S_RUN, so a counter still in its waiting state never causes a spurious result.
REQ-023 data is registered and holds its last issued value until the next S_ISSUE.
REQ-024 start and result_valid are registered outputs and are never combinational from any input.
REQ-025 Latency: a word accepted into an empty FIFO with the FSM in S_IDLE sees start asserted in the second cycle after the accepting edge.
REQ-026 busy is monitoring-only; progress relies on done in S_RUN; busy=1 in S_IDLE is ignored.
REQ-027 FIFO pointers are log2(fifo_depth) bits plus a wrap bit; full/empty are derived from pointer equality and wrap bit; pointers wrap modulo depth.
REQ-028 Simultaneous push and pop on a non-full FIFO: both take effect and the occupancy is unchanged.

Reset
REQ-029 Reset asserted: FSM -> S_IDLE, FIFO empty, data=0, start=0, result_count=0, result_valid=0; in_ready=1 once the FIFO is empty.
REQ-030 Reset mid-operation abandons the in-flight word and all buffered words; no result_valid is produced for them.

Configuration
REQ-031 Macro COUNT_ONES_FEEDER_LEVEL_EN defined: adds output fifo_level, width log2(fifo_depth)+1, holding current occupancy, reset 0.
REQ-032 Macro undefined: port fifo_level and its logic are absent; all other behaviour is identical.

Structure
REQ-033 Shared package count_ones_pkg holds the FSM state encoding (S_IDLE=0, S_ISSUE=1, S_RUN=2, 2 bits) and the default word_size, counter_size and fifo_depth constants.
REQ-034 A single sub-module feeder_fifo (synchronous FIFO with full/empty and level) is instantiated; the FSM and result capture live in count_ones_feeder.

Verification (bench connects count_ones_feeder to the ones counter, shared clk/reset)
REQ-035 Push 4'b1011 once -> exactly one start pulse, 2 cycles after acceptance; then result_valid with result_count=3.
REQ-036 Push 4'b0000, then 4'b1111 back-to-back -> results in order: 0, then 4; exactly two start pulses.
REQ-037 Push 5 words with the FIFO never drained (depth 4) -> in_ready=0 after the 4th pending entry; no word is lost; all 5 results correct and in order.
REQ-038 Assert reset while in S_RUN with 2 words queued -> no further start or result_valid; all outputs at reset values; a subsequent push of 4'b0110 yields result_count=2.
REQ-039 Hold in_valid=1 with a full FIFO while a pop occurs -> the push is refused that cycle and accepted the next cycle.
REQ-040 With COUNT_ONES_FEEDER_LEVEL_EN: push 3 words while the counter runs -> fifo_level follows the occupancy exactly (steps 1, 2, 3, then decrements on each S_ISSUE exit).

Source files
------------

// File: rtl/count_ones_pkg.sv
// Shared constants for the ones-counter feeder: default sizes and the FSM state encoding.
package count_ones_pkg;

  localparam int DEFAULT_WORD_SIZE    = 4;
  localparam int DEFAULT_COUNTER_SIZE = 3;
  localparam int DEFAULT_FIFO_DEPTH   = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/feeder_fifo.sv
// Synchronous FIFO: head visible combinationally, pop/push take effect on the edge; full refuses
// pushes regardless of a same-cycle pop. Pointers carry one wrap bit above the address.
module feeder_fifo #(
  parameter int width = 4,
  parameter int depth = 4,
  localparam int aw   = $clog2(depth)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             pop,
  output logic [width-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [aw:0]      level
);

  logic [width-1:0] mem [depth];
  logic [aw:0]      wr_ptr;
  logic [aw:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Same address with differing wrap bits means the writer has lapped the reader.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[aw] != rd_ptr[aw]) && (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign head    = mem[rd_ptr[aw-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[aw-1:0]] <= push_data;
  end

endmodule

// File: rtl/count_ones_feeder.sv
// Buffers words and launches them one at a time into a ones counter; start two cycles after an idle accept.
// in_ready is FIFO-not-full only. Optional fifo_level output under COUNT_ONES_FEEDER_LEVEL_EN.
module count_ones_feeder
  import count_ones_pkg::*;
#(
  parameter int word_size    = DEFAULT_WORD_SIZE,
  parameter int counter_size = DEFAULT_COUNTER_SIZE,
  parameter int fifo_depth   = DEFAULT_FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [word_size-1:0]    in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [word_size-1:0]    data,
  output logic                    start,
  input  logic                    busy,
  input  logic                    done,
  input  logic [counter_size-1:0] bit_count,
  output logic [counter_size-1:0] result_count,
`ifdef COUNT_ONES_FEEDER_LEVEL_EN
  output logic [$clog2(fifo_depth):0] fifo_level,
`endif
  output logic                    result_valid
);

  localparam int level_w = $clog2(fifo_depth) + 1;

  state_t               state;
  state_t               state_next;
  logic [word_size-1:0] fifo_head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [level_w-1:0]   occupancy;
  logic                 launch;
  logic                 finish;

  feeder_fifo #(
    .width (word_size),
    .depth (fifo_depth)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (state == S_ISSUE),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (occupancy)
  );

  assign in_ready = !fifo_full;
  assign launch   = (state == S_IDLE) && !fifo_empty;
  // done only counts while we own a launched word; a counter parked in its waiting state is ignored.
  assign finish   = (state == S_RUN) && done;

`ifdef COUNT_ONES_FEEDER_LEVEL_EN
  assign fifo_level = occupancy;
`else
  logic unused_occupancy;
  assign unused_occupancy = ^occupancy;
`endif

  logic unused_busy;
  assign unused_busy = busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (launch) state_next = S_ISSUE;
      S_ISSUE: state_next = S_RUN;
      S_RUN:   if (finish) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // start mirrors S_ISSUE and data is loaded on the same edge, so both are flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start        <= 1'b0;
      data         <= '0;
      result_count <= '0;
      result_valid <= 1'b0;
    end else begin
      start        <= launch;
      result_valid <= finish;
      if (launch) data <= fifo_head;
      if (finish) result_count <= bit_count;
    end
  end

endmodule
